// File: rtl/stack_pkg.sv
// ============================================================================
// stack_pkg : op codes, FSM state type and default sizes for stack_master
// Revision  : 1.0
// ============================================================================
`default_nettype none

package stack_pkg;

  localparam int unsigned DEFAULT_DATA_W = 4;
  localparam int unsigned DEFAULT_DEPTH  = 8;
  localparam int unsigned DEFAULT_IDX_W  = 3;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_GET  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/stack_occ_tracker.sv
// ============================================================================
// stack_occ_tracker : occupancy counter, FULL/EMPTY flags, request legality
// Option            : STACK_MASTER_WRAP_EN makes a push while full legal
// Revision          : 1.0
// ============================================================================
`default_nettype none

module stack_occ_tracker
  import stack_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [1:0]       chk_op,
  input  logic [IDX_W-1:0] chk_index,
  output logic             chk_legal,
  input  logic             upd_en,
  input  logic [1:0]       upd_op,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [IDX_W:0] C_DEPTH_CNT = DEPTH[IDX_W:0];

  logic [IDX_W:0] count_d;
  logic [IDX_W:0] count_q;

  assign count = count_q;
  assign full  = (count_q == C_DEPTH_CNT);
  assign empty = (count_q == '0);

  // Saturating update: a ring-mode push while full keeps COUNT at DEPTH.
  always_comb begin
    count_d = count_q;
    if (upd_en) begin
      if ((upd_op == OP_PUSH) && !full) begin
        count_d = count_q + 1'b1;
      end else if ((upd_op == OP_POP) && !empty) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_comb begin
    chk_legal = 1'b1;
    case (chk_op)
`ifdef STACK_MASTER_WRAP_EN
      OP_PUSH: chk_legal = 1'b1;
`else
      OP_PUSH: chk_legal = !full;
`endif
      OP_POP:  chk_legal = !empty;
      OP_GET:  chk_legal = ({1'b0, chk_index} < count_q);
      default: chk_legal = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stack_master.sv
// ============================================================================
// stack_master : valid/ready command initiator for an 8x4 stack
// Option       : STACK_MASTER_WRAP_EN (ring push while full, see tracker)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module stack_master
  import stack_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [1:0]        REQ_OP,
  input  logic [IDX_W-1:0]  REQ_INDEX,
  input  logic [DATA_W-1:0] REQ_DATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_ERR,
  output logic              STK_RESET,
  output logic [1:0]        STK_COMMAND,
  output logic [IDX_W-1:0]  STK_INDEX,
  output logic [DATA_W-1:0] STK_DATA,
  input  logic [DATA_W-1:0] STK_O_DATA,
  output logic [IDX_W:0]    COUNT,
  output logic              FULL,
  output logic              EMPTY
);

  state_e            state_d,     state_q;
  logic [1:0]        cmd_d,       cmd_q;
  logic [1:0]        op_d,        op_q;
  logic [IDX_W-1:0]  index_d,     index_q;
  logic [DATA_W-1:0] data_d,      data_q;
  logic              rsp_valid_d, rsp_valid_q;
  logic              rsp_err_d,   rsp_err_q;
  logic [DATA_W-1:0] rsp_data_d,  rsp_data_q;
  logic              req_legal;

  stack_occ_tracker #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_occ (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .chk_op    (REQ_OP),
    .chk_index (REQ_INDEX),
    .chk_legal (req_legal),
    .upd_en    (state_q == ST_ISSUE),
    .upd_op    (op_q),
    .count     (COUNT),
    .full      (FULL),
    .empty     (EMPTY)
  );

  assign STK_RESET   = !RESET_N;
  assign REQ_READY   = (state_q == ST_IDLE);
  assign STK_COMMAND = cmd_q;
  assign STK_INDEX   = index_q;
  assign STK_DATA    = data_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_ERR     = rsp_err_q;
  assign RSP_DATA    = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    op_d        = op_q;
    index_d     = index_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        // NOP is consumed here without producing a response.
        if (REQ_VALID && (REQ_OP != OP_NOP)) begin
          if (req_legal) begin
            cmd_d   = REQ_OP;
            op_d    = REQ_OP;
            index_d = REQ_INDEX;
            data_d  = REQ_DATA;
            state_d = ST_ISSUE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            state_d     = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        cmd_d   = OP_NOP;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = (op_q == OP_PUSH) ? '0 : STK_O_DATA;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cmd_q       <= OP_NOP;
      op_q        <= OP_NOP;
      index_q     <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      op_q        <= op_d;
      index_q     <= index_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stack_master.sv
// ============================================================================
// tb_stack_master : directed self-checking bench for stack_master
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_stack_master;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [1:0] REQ_OP = 2'b00;
  logic [2:0] REQ_INDEX = 3'd0;
  logic [3:0] REQ_DATA = 4'd0;
  logic       RSP_VALID;
  logic [3:0] RSP_DATA;
  logic       RSP_ERR;
  logic       STK_RESET;
  logic [1:0] STK_COMMAND;
  logic [2:0] STK_INDEX;
  logic [3:0] STK_DATA;
  logic [3:0] STK_O_DATA = 4'd0;
  logic [3:0] COUNT;
  logic       FULL;
  logic       EMPTY;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  stack_master dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_OP      (REQ_OP),
    .REQ_INDEX   (REQ_INDEX),
    .REQ_DATA    (REQ_DATA),
    .RSP_VALID   (RSP_VALID),
    .RSP_DATA    (RSP_DATA),
    .RSP_ERR     (RSP_ERR),
    .STK_RESET   (STK_RESET),
    .STK_COMMAND (STK_COMMAND),
    .STK_INDEX   (STK_INDEX),
    .STK_DATA    (STK_DATA),
    .STK_O_DATA  (STK_O_DATA),
    .COUNT       (COUNT),
    .FULL        (FULL),
    .EMPTY       (EMPTY)
  );

  // Behavioural stack: mem[0] is the top; a push while full drops the oldest.
  logic [3:0] mem [8];
  always @(posedge CLK) begin
    if (STK_RESET) begin
      for (int i = 0; i < 8; i++) mem[i] = 4'd0;
      STK_O_DATA <= 4'd0;
    end else begin
      case (STK_COMMAND)
        2'b01: begin
          for (int i = 7; i > 0; i--) mem[i] = mem[i-1];
          mem[0] = STK_DATA;
        end
        2'b10: begin
          STK_O_DATA <= mem[0];
          for (int i = 0; i < 7; i++) mem[i] = mem[i+1];
          mem[7] = 4'd0;
        end
        2'b11: STK_O_DATA <= mem[STK_INDEX];
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a negedge; checks every cycle of the transaction.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [2:0] idx,
                        input logic [3:0] d, input logic exp_err, input logic [3:0] exp_data);
    int waited = 0;
    while (REQ_READY !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (REQ_READY !== 1'b1) begin
      check({tag, "_ready_timeout"}, 32'(REQ_READY), 32'd1);
      return;
    end
    REQ_VALID = 1'b1;
    REQ_OP    = op;
    REQ_INDEX = idx;
    REQ_DATA  = d;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    REQ_DATA  = ~d;
    REQ_INDEX = ~idx;
    if (exp_err) begin
      check({tag, "_err_valid"}, 32'(RSP_VALID), 32'd1);
      check({tag, "_err_flag"}, 32'(RSP_ERR), 32'd1);
      check({tag, "_err_data"}, 32'(RSP_DATA), 32'd0);
      check({tag, "_err_cmd"}, 32'(STK_COMMAND), 32'd0);
      @(negedge CLK);
      check({tag, "_err_ready"}, 32'(REQ_READY), 32'd1);
      check({tag, "_err_valid_off"}, 32'(RSP_VALID), 32'd0);
    end else begin
      check({tag, "_cmd"}, 32'(STK_COMMAND), 32'(op));
      check({tag, "_rsp_early"}, 32'(RSP_VALID), 32'd0);
      if (op == 2'b11) check({tag, "_index"}, 32'(STK_INDEX), 32'(idx));
      if (op == 2'b01) check({tag, "_wdata"}, 32'(STK_DATA), 32'(d));
      @(negedge CLK);
      check({tag, "_cmd_off"}, 32'(STK_COMMAND), 32'd0);
      check({tag, "_rsp_wait"}, 32'(RSP_VALID), 32'd0);
      @(negedge CLK);
      check({tag, "_rsp_valid"}, 32'(RSP_VALID), 32'd1);
      check({tag, "_rsp_err"}, 32'(RSP_ERR), 32'd0);
      check({tag, "_rsp_data"}, 32'(RSP_DATA), 32'(exp_data));
      check({tag, "_busy"}, 32'(REQ_READY), 32'd0);
      @(negedge CLK);
      check({tag, "_ready"}, 32'(REQ_READY), 32'd1);
      check({tag, "_rsp_off"}, 32'(RSP_VALID), 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_cmd", 32'(STK_COMMAND), 32'd0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    check("rst_rsp_data", 32'(RSP_DATA), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_stk_reset", 32'(STK_RESET), 32'd1);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("rel_ready", 32'(REQ_READY), 32'd1);
    check("rel_stk_reset", 32'(STK_RESET), 32'd0);

    do_req("push3", 2'b01, 3'd0, 4'h3, 1'b0, 4'h0);
    do_req("push5", 2'b01, 3'd0, 4'h5, 1'b0, 4'h0);
    do_req("push9", 2'b01, 3'd0, 4'h9, 1'b0, 4'h0);
    check("count3", 32'(COUNT), 32'd3);

    do_req("get0", 2'b11, 3'd0, 4'h0, 1'b0, 4'h9);
    do_req("get2", 2'b11, 3'd2, 4'h0, 1'b0, 4'h3);
    do_req("get3", 2'b11, 3'd3, 4'h0, 1'b1, 4'h0);
    check("count_after_get", 32'(COUNT), 32'd3);

    do_req("pop_a", 2'b10, 3'd0, 4'h0, 1'b0, 4'h9);
    do_req("pop_b", 2'b10, 3'd0, 4'h0, 1'b0, 4'h5);
    do_req("pop_c", 2'b10, 3'd0, 4'h0, 1'b0, 4'h3);
    check("empty_after_pops", 32'(EMPTY), 32'd1);
    do_req("pop_empty", 2'b10, 3'd0, 4'h0, 1'b1, 4'h0);
    check("count_after_underflow", 32'(COUNT), 32'd0);

    for (int i = 1; i <= 8; i++) do_req("fill", 2'b01, 3'd0, 4'(i), 1'b0, 4'h0);
    check("full_set", 32'(FULL), 32'd1);
    check("count8", 32'(COUNT), 32'd8);
`ifdef STACK_MASTER_WRAP_EN
    do_req("push_full_wrap", 2'b01, 3'd0, 4'hF, 1'b0, 4'h0);
    check("count_wrap", 32'(COUNT), 32'd8);
    do_req("get_wrap_top", 2'b11, 3'd0, 4'h0, 1'b0, 4'hF);
    do_req("get_wrap_bot", 2'b11, 3'd7, 4'h0, 1'b0, 4'h2);
`else
    do_req("push_full", 2'b01, 3'd0, 4'hF, 1'b1, 4'h0);
    check("count_overflow", 32'(COUNT), 32'd8);
    do_req("get_full_top", 2'b11, 3'd0, 4'h0, 1'b0, 4'h8);
`endif

    // Reset arrives in the WAIT cycle of a pop.
    REQ_VALID = 1'b1;
    REQ_OP    = 2'b10;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("rpop_cmd", 32'(STK_COMMAND), 32'd2);
    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    check("rpop_no_rsp", 32'(RSP_VALID), 32'd0);
    check("rpop_count", 32'(COUNT), 32'd0);
    check("rpop_stk_reset", 32'(STK_RESET), 32'd1);
    check("rpop_cmd_off", 32'(STK_COMMAND), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("rpop_ready", 32'(REQ_READY), 32'd1);
    check("rpop_no_rsp_after", 32'(RSP_VALID), 32'd0);
    check("rpop_empty", 32'(EMPTY), 32'd1);

    // REQ_VALID held high with data changing every cycle.
    REQ_OP    = 2'b01;
    REQ_VALID = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge CLK);
      REQ_DATA = 4'(k + 1);
      check("hold_ready", 32'(REQ_READY), 32'((k % 4) == 0));
      check("hold_rsp", 32'(RSP_VALID), 32'((k % 4) == 3));
    end
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("hold_count", 32'(COUNT), 32'd3);
    do_req("hold_pop_a", 2'b10, 3'd0, 4'h0, 1'b0, 4'h9);
    do_req("hold_pop_b", 2'b10, 3'd0, 4'h0, 1'b0, 4'h5);
    do_req("hold_pop_c", 2'b10, 3'd0, 4'h0, 1'b0, 4'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
